// File: rtl/reg_file_sb_pkg.sv
// reg_file_sb_pkg: default widths and sweep FSM state type for reg_file_sb
package reg_file_sb_pkg;
    localparam int DATA_WIDTH_D = 32;
    localparam int ADDR_WIDTH_D = 5;
    typedef enum logic {CLEAR, READY} state_t;
endpackage

// File: rtl/reg_file_sb_scb.sv
// reg_file_sb_scb: per-register busy (pending-producer) bits with set-over-write-clear priority
// Ports: clk, rst (async, active-high); i_clr wipes all bits; i_wen/i_waddr and
// i_pwen/i_pwaddr clear bits of written registers; i_set_en/i_set_addr sets a bit;
// i_raddr1/2 select o_rbusy1/2 from registered state.
module reg_file_sb_scb
    import reg_file_sb_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_D
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_clr,
    input  logic                  i_wen,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic                  i_pwen,
    input  logic [ADDR_WIDTH-1:0] i_pwaddr,
    input  logic                  i_set_en,
    input  logic [ADDR_WIDTH-1:0] i_set_addr,
    input  logic [ADDR_WIDTH-1:0] i_raddr1,
    input  logic [ADDR_WIDTH-1:0] i_raddr2,
    output logic                  o_rbusy1,
    output logic                  o_rbusy2
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    logic [DEPTH-1:0] r_busy;
    logic [DEPTH-1:0] w_busy_nxt;
    always_comb begin
        w_busy_nxt = r_busy;
        if (i_wen) w_busy_nxt[i_waddr] = 1'b0;
        if (i_pwen) begin
            w_busy_nxt[i_pwaddr & ~ADDR_WIDTH'(1)] = 1'b0;
            w_busy_nxt[i_pwaddr | ADDR_WIDTH'(1)]  = 1'b0;
        end
        // set is applied last so it wins over a same-cycle write clear
        if (i_set_en) w_busy_nxt[i_set_addr] = 1'b1;
        w_busy_nxt[0] = 1'b0;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_busy <= '0;
        else     r_busy <= i_clr ? '0 : w_busy_nxt;
    end
    assign o_rbusy1 = r_busy[i_raddr1];
    assign o_rbusy2 = r_busy[i_raddr2];
endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb: 2-read register file with single + pair write ports, busy scoreboard and zeroing sweep
// Ports: clk, rst (async, active-high), clr (restart sweep); wen/waddr/wdata single
// write; pwen/pwaddr/pwdata even/odd pair write; set_en/set_addr mark busy;
// raddr1/2 -> rdata1/2, rbusy1/2 combinational; ready high once swept.
// Macro REG_FILE_SB_BYPASS_EN: same-cycle write data forwarded to reads.
module reg_file_sb
    import reg_file_sb_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_D,
    parameter int ADDR_WIDTH = ADDR_WIDTH_D
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    wen,
    input  logic [ADDR_WIDTH-1:0]   waddr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic                    pwen,
    input  logic [ADDR_WIDTH-1:0]   pwaddr,
    input  logic [2*DATA_WIDTH-1:0] pwdata,
    input  logic                    set_en,
    input  logic [ADDR_WIDTH-1:0]   set_addr,
    input  logic [ADDR_WIDTH-1:0]   raddr1,
    input  logic [ADDR_WIDTH-1:0]   raddr2,
    output logic [DATA_WIDTH-1:0]   rdata1,
    output logic [DATA_WIDTH-1:0]   rdata2,
    output logic                    rbusy1,
    output logic                    rbusy2,
    output logic                    ready
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    state_t                r_state, w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_cnt, w_cnt_nxt;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic                  w_ready, w_wen, w_pwen, w_busy1, w_busy2;
    logic [ADDR_WIDTH-1:0] w_pe, w_po;
    logic [DATA_WIDTH-1:0] w_plo, w_phi;
    logic [ADDR_WIDTH-1:0] w_ra [2];

    assign w_ready = (r_state == READY);
    assign w_wen   = wen && w_ready && (waddr != '0);
    assign w_pwen  = pwen && w_ready;
    assign w_pe    = pwaddr & ~ADDR_WIDTH'(1);
    assign w_po    = pwaddr | ADDR_WIDTH'(1);
    assign w_plo   = pwdata[DATA_WIDTH-1:0];
    assign w_phi   = pwdata[2*DATA_WIDTH-1:DATA_WIDTH];
    assign w_ra[0] = raddr1;
    assign w_ra[1] = raddr2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= CLEAR;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = '0;
        if (r_state == CLEAR) begin
            w_state_nxt = (!clr && r_cnt == ADDR_WIDTH'(DEPTH - 1)) ? READY : CLEAR;
            w_cnt_nxt   = (clr || r_cnt == ADDR_WIDTH'(DEPTH - 1)) ? '0 : r_cnt + 1'b1;
        end else if (clr) begin
            w_state_nxt = CLEAR;
        end
    end

    // array has no reset; the sweep zeroes one entry per cycle instead
    always_ff @(posedge clk) begin
        if (!w_ready) begin
            r_mem[r_cnt] <= '0;
        end else begin
            if (w_wen) r_mem[waddr] <= wdata;
            // pair write follows the single write so it wins on overlap
            if (w_pwen) begin
                if (w_pe != '0) r_mem[w_pe] <= w_plo;
                r_mem[w_po] <= w_phi;
            end
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_rd
        logic [DATA_WIDTH-1:0] w_d;
        always_comb begin
            w_d = r_mem[w_ra[g]];
`ifdef REG_FILE_SB_BYPASS_EN
            if (w_wen && waddr == w_ra[g]) w_d = wdata;
            if (w_pwen && w_pe == (w_ra[g] & ~ADDR_WIDTH'(1))) w_d = w_ra[g][0] ? w_phi : w_plo;
`endif
            if (!w_ready || w_ra[g] == '0) w_d = '0;
        end
    end

    reg_file_sb_scb #(.ADDR_WIDTH(ADDR_WIDTH)) u_scb (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (clr || !w_ready),
        .i_wen      (w_wen),
        .i_waddr    (waddr),
        .i_pwen     (w_pwen),
        .i_pwaddr   (pwaddr),
        .i_set_en   (set_en && w_ready),
        .i_set_addr (set_addr),
        .i_raddr1   (raddr1),
        .i_raddr2   (raddr2),
        .o_rbusy1   (w_busy1),
        .o_rbusy2   (w_busy2)
    );

    assign rdata1 = g_rd[0].w_d;
    assign rdata2 = g_rd[1].w_d;
    assign rbusy1 = w_ready && w_busy1;
    assign rbusy2 = w_ready && w_busy2;
    assign ready  = w_ready;
endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed scoreboard bench for reg_file_sb
module tb_reg_file_sb;
    logic        clk = 0, rst = 1, clr = 0, wen = 0, pwen = 0, set_en = 0;
    logic [4:0]  waddr = 0, pwaddr = 0, set_addr = 0, raddr1 = 0, raddr2 = 0;
    logic [31:0] wdata = 0;
    logic [63:0] pwdata = 0;
    logic [31:0] rdata1, rdata2;
    logic        rbusy1, rbusy2, ready;
    int          errors = 0, checks = 0, n;
    logic [31:0] q[$];

    reg_file_sb dut (
        .clk(clk), .rst(rst), .clr(clr), .wen(wen), .waddr(waddr), .wdata(wdata),
        .pwen(pwen), .pwaddr(pwaddr), .pwdata(pwdata), .set_en(set_en), .set_addr(set_addr),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
        .rbusy1(rbusy1), .rbusy2(rbusy2), .ready(ready)
    );

    always #5 clk = ~clk;

    task automatic push(input logic [31:0] e);
        q.push_back(e);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        checks++;
        if (q.size() == 0) begin
            errors++;
            $error("FAIL %s scoreboard empty, observed=%h", tag, obs);
            return;
        end
        e = q.pop_front();
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, e);
        end
    endtask

    task automatic wait_ready(output int cnt);
        cnt = 0;
        while (!ready && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
    endtask

    task automatic idle();
        wen = 0; pwen = 0; set_en = 0; clr = 0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        push(0); chk("rst_ready", {31'b0, ready});
        push(0); chk("rst_rbusy", {31'b0, rbusy1});
        rst = 0;
        for (int i = 0; i < 32; i++) begin
            #1 push(0); chk($sformatf("sweep_ready_%0d", i), {31'b0, ready});
            @(negedge clk);
        end
        #1 push(1); chk("sweep_done", {31'b0, ready});
        for (int i = 0; i < 32; i++) begin
            raddr1 = 5'(i); raddr2 = 5'(31 - i);
            #0.1 push(0); chk($sformatf("init_r1_%0d", i), rdata1);
            push(0); chk($sformatf("init_r2_%0d", i), rdata2);
        end
        // single write, same-cycle read
        @(negedge clk);
        wen = 1; waddr = 5; wdata = 32'hDEADBEEF; raddr1 = 5; raddr2 = 4;
`ifdef REG_FILE_SB_BYPASS_EN
        push(32'hDEADBEEF);
`else
        push(0);
`endif
        #1 chk("wr5_same", rdata1);
        push(0); chk("wr5_neighbour", rdata2);
        push(32'hDEADBEEF);
        @(negedge clk); idle();
        #1 chk("wr5_next", rdata1);
        // overlapping pair and single writes
        @(negedge clk);
        pwen = 1; pwaddr = 7; pwdata = 64'h11111111_22222222;
        wen = 1; waddr = 6; wdata = 32'h33; raddr1 = 6; raddr2 = 7;
`ifdef REG_FILE_SB_BYPASS_EN
        push(32'h22222222); push(32'h11111111);
`else
        push(0); push(0);
`endif
        #1 chk("pair_same_r6", rdata1);
        chk("pair_same_r7", rdata2);
        push(32'h22222222); push(32'h11111111);
        @(negedge clk); idle();
        #1 chk("pair_r6", rdata1);
        chk("pair_r7", rdata2);
        // non-overlapping pair and single writes
        @(negedge clk);
        pwen = 1; pwaddr = 10; pwdata = 64'hAAAA0001_BBBB0002;
        wen = 1; waddr = 12; wdata = 32'h44;
        push(32'hBBBB0002); push(32'hAAAA0001); push(32'h44);
        @(negedge clk); idle();
        raddr1 = 10; raddr2 = 11;
        #1 chk("pair_r10", rdata1);
        chk("pair_r11", rdata2);
        raddr1 = 12;
        #1 chk("single_r12", rdata1);
        // busy set / clear / priority
        @(negedge clk);
        set_en = 1; set_addr = 9; raddr1 = 9;
        #1 push(0); chk("busy9_same", {31'b0, rbusy1});
        @(negedge clk); idle();
        #1 push(1); chk("busy9_set", {31'b0, rbusy1});
        @(negedge clk);
        wen = 1; waddr = 9; wdata = 32'h99;
        #1 push(1); chk("busy9_wr_same", {31'b0, rbusy1});
        @(negedge clk); idle();
        #1 push(0); chk("busy9_cleared", {31'b0, rbusy1});
        push(32'h99); chk("reg9_data", rdata1);
        @(negedge clk);
        set_en = 1; set_addr = 9; wen = 1; waddr = 9; wdata = 32'h98;
        @(negedge clk); idle();
        #1 push(1); chk("busy9_set_wins", {31'b0, rbusy1});
        push(32'h98); chk("reg9_data2", rdata1);
        // pair write clears odd-register busy
        @(negedge clk);
        set_en = 1; set_addr = 15; raddr2 = 15;
        @(negedge clk); idle();
        #1 push(1); chk("busy15_set", {31'b0, rbusy2});
        pwen = 1; pwaddr = 14; pwdata = 64'h5;
        @(negedge clk); idle();
        #1 push(0); chk("busy15_pair_clr", {31'b0, rbusy2});
        // register 0
        @(negedge clk);
        wen = 1; waddr = 0; wdata = 32'hFFFFFFFF; set_en = 1; set_addr = 0; raddr1 = 0;
        #1 push(0); chk("r0_same", rdata1);
        @(negedge clk); idle();
        #1 push(0); chk("r0_data", rdata1);
        push(0); chk("r0_busy", {31'b0, rbusy1});
        // clr sweep
        @(negedge clk);
        wen = 1; waddr = 3; wdata = 32'hA5; set_en = 1; set_addr = 13;
        @(negedge clk); idle();
        raddr1 = 3; raddr2 = 13;
        #1 push(32'hA5); chk("r3_before_clr", rdata1);
        push(1); chk("busy13_before_clr", {31'b0, rbusy2});
        @(negedge clk); clr = 1;
        @(negedge clk); clr = 0;
        for (int i = 0; i < 32; i++) begin
            wen = 1; waddr = 3; wdata = 32'h77; set_en = 1; set_addr = 3;
            #1 push(0); chk($sformatf("clr_ready_%0d", i), {31'b0, ready});
            if (i == 0 || i == 31) begin
                push(0); chk("clr_rdata", rdata1);
                push(0); chk("clr_rbusy", {31'b0, rbusy2});
            end
            @(negedge clk);
        end
        idle();
        #1 push(1); chk("clr_done", {31'b0, ready});
        push(0); chk("r3_after_clr", rdata1);
        push(0); chk("busy13_after_clr", {31'b0, rbusy2});
        raddr2 = 3;
        #1 push(0); chk("busy3_after_clr", {31'b0, rbusy2});
        // clr during CLEAR restarts the sweep
        @(negedge clk); clr = 1;
        @(negedge clk); clr = 0;
        repeat (10) @(negedge clk);
        clr = 1;
        @(negedge clk); clr = 0;
        wait_ready(n);
        push(32); chk("clr_restart_len", n);
        // rst in the middle of a write
        @(negedge clk);
        wen = 1; waddr = 20; wdata = 32'h12345678; raddr1 = 20;
        #2 rst = 1;
        #1 push(0); chk("rst_async_ready", {31'b0, ready});
        @(negedge clk); idle(); rst = 0;
        wait_ready(n);
        push(32); chk("rst_sweep_len", n);
        #1 push(0); chk("r20_after_rst", rdata1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
- REQ-001 DATA_WIDTH, 32, width of each register.
- REQ-002 ADDR_WIDTH, 5, address width; DEPTH = 2**ADDR_WIDTH registers.
- REQ-003 clk  in  1  single clock, all state on rising edge.
- REQ-004 rst  in  1  reset, asynchronous, active-high.
- REQ-005 clr  in  1  synchronous request to restart the clear sweep.
- REQ-006 wen  in  1  single write enable.
- REQ-007 waddr  in  ADDR_WIDTH  single write address.
- REQ-008 wdata  in  DATA_WIDTH  single write data.
- REQ-009 pwen  in  1  pair write enable.
- REQ-010 pwaddr  in  ADDR_WIDTH  pair base address; bit 0 ignored.
- REQ-011 pwdata  in  2*DATA_WIDTH  pair data; low half to even register, high half to odd register.
- REQ-012 set_en  in  1  mark a register pending (producer issued).
- REQ-013 set_addr  in  ADDR_WIDTH  register to mark pending.
- REQ-014 raddr1, raddr2  in  ADDR_WIDTH  read addresses.
- REQ-015 rdata1, rdata2  out  DATA_WIDTH  combinational read data.
- REQ-016 rbusy1, rbusy2  out  1  pending flag of the addressed register.
- REQ-017 ready  out  1  high when the array is initialised and accepting writes.

Function
- REQ-018 Register 0 SHALL always read 0, never be written, and never be busy.
- REQ-019 FSM SHALL have states CLEAR and READY; a sweep counter SHALL step 0..DEPTH-1 in CLEAR, writing zero to one register per cycle.
- REQ-020 CLEAR SHALL go to READY on the cycle after the counter reaches DEPTH-1; sweep length is exactly DEPTH cycles.
- REQ-021 clr in READY SHALL return to CLEAR with counter 0 and clear all busy bits on the next edge; clr in CLEAR SHALL restart the counter at 0.
- REQ-022 In CLEAR, wen, pwen and set_en SHALL be ignored, rdata1/2 SHALL be 0, and rbusy1/2 SHALL be 0.
- REQ-023 In READY, wen SHALL write wdata to waddr at the edge.
- REQ-024 In READY, pwen SHALL write pwdata low half to {pwaddr[ADDR_WIDTH-1:1],0} and high half to {pwaddr[ADDR_WIDTH-1:1],1}, in the same edge.
- REQ-025 If wen and pwen target the same register in one cycle, the pair write SHALL win for that register; a non-overlapping single write SHALL still occur.
- REQ-026 Any write to register r SHALL clear busy[r] at that edge.
- REQ-027 set_en SHALL set busy[set_addr]; when set and a write hit the same register in one cycle, set SHALL win (busy stays 1).
- REQ-028 rbusy SHALL reflect registered busy state (no same-cycle forwarding of set_en or writes).
- REQ-029 Reads SHALL be combinational, with write/bypass behaviour per Configuration.

Reset
- REQ-030 On rst, the FSM SHALL enter CLEAR with counter 0, all busy bits 0, ready=0, rdata1/2=0, and rbusy1/2=0.
- REQ-031 Array contents SHALL NOT be asynchronously reset; they are zeroed only by the sweep.
- REQ-032 rst asserted mid-sweep or mid-write SHALL abort the operation; the interrupted write has no effect on the final state, because the sweep restarts.

Configuration
- REQ-033 Macro REG_FILE_SB_BYPASS_EN: when defined, in READY a read of a register being written in the same cycle SHALL return the new data (pair over single per REQ-025); when undefined, it SHALL return the old stored value.

Structure
- REQ-034 Package reg_file_sb_pkg SHALL hold the default width constants and the FSM state typedef (CLEAR, READY).
- REQ-035 Busy bits and their set/clear priority SHALL live in sub-module reg_file_sb_scb; the array, sweep FSM and read muxing stay in reg_file_sb.

Verification
- REQ-036 Release rst, hold other inputs at 0 -> ready=0 for 32 cycles, then 1; all 32 registers read 0.
- REQ-037 READY, wen=1 waddr=5 wdata=0xDEADBEEF, raddr1=5 in the same cycle -> rdata1=0xDEADBEEF with bypass, 0 without; the next cycle -> 0xDEADBEEF in both builds.
- REQ-038 pwen=1 pwaddr=7 pwdata=0x11111111_22222222 with wen=1 waddr=6 wdata=0x33 -> reg6=0x22222222, reg7=0x11111111.
- REQ-039 set_en addr=9 -> rbusy(9)=1 from the next cycle; wen to 9 -> busy clears; set_en and wen to 9 in the same cycle -> busy remains 1.
- REQ-040 wen=1 waddr=0 wdata=0xFFFFFFFF, and set_en addr=0 -> reg0 reads 0, rbusy=0.
- REQ-041 clr pulse after writing reg3=0xA5 -> ready=0 for 32 cycles, writes ignored, then reg3=0 and all busy bits 0.
